dvs_event_prefetch_buffer: RTL

- Parametrised successor to the single-event DVS FIFO reader.
- Arbitrates for the shared FIFO event bus and reads DVS events ahead of demand into a local circular buffer of DEPTH entries.
- Presents events to the RAVENS transmitter over a valid/ready interface, so bus reads overlap spike transmission.
- Supports FIFO read latencies greater than one cycle; stale-event dropping can be compiled in.

---
 rtl/dvs_event_prefetch_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dvs_event_prefetch_buffer.sv
// Prefetching DVS event reader: arbitrates for the shared FIFO bus and keeps a DEPTH-entry
// circular buffer of events ahead of the RAVENS transmitter. Define DVS_STALE_DROP_EN to drop stale events.
`ifndef EVENT_BITS
`define EVENT_BITS 32
`endif
`ifndef TIMESTAMP_US_BITS
`define TIMESTAMP_US_BITS 16
`endif

module dvs_event_prefetch_buffer #(
  parameter int EVENT_W    = `EVENT_BITS,
  parameter int DEPTH      = 4,
  parameter int RD_LATENCY = 1,
  parameter int STALE_US   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_grant,
  input  logic [EVENT_W-1:0]            fifo_event,
  input  logic [`TIMESTAMP_US_BITS-1:0] time_us,
  input  logic                          spike_ready,
  output logic                          fifo_req,
  output logic                          fifo_rd_en,
  output logic                          spike_valid,
  output logic [EVENT_W-1:0]            spike_event,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [15:0]                   drop_count
);

  localparam int TS_W      = `TIMESTAMP_US_BITS;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int OCC_W     = $clog2(DEPTH + 1);
  localparam int WCNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int WAIT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  localparam logic [OCC_W-1:0]  DEPTH_OCC   = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(DEPTH - 1);
  localparam logic [WCNT_W-1:0] WAIT_LOAD_C = WCNT_W'(WAIT_LOAD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_CTRL,
    ST_WAIT,
    ST_READ
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [EVENT_W-1:0]  mem [DEPTH];
  logic                req_int;
  logic                capture;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    next_ptr = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // ---- read-control FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (fifo_grant && req_int) state_nxt = ST_READ_CTRL;
      ST_READ_CTRL: state_nxt = (RD_LATENCY == 1) ? ST_READ : ST_WAIT;
      ST_WAIT:      if (wait_cnt == '0) state_nxt = ST_READ;
      ST_READ:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_int    = 1'b0;
    fifo_rd_en = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE:      req_int    = (occupancy < DEPTH_OCC);
      ST_READ_CTRL: fifo_rd_en = 1'b1;
      ST_READ:      capture    = 1'b1;
      default:      ;
    endcase
  end

  // Request is forced low while reset is asserted so every output reads 0 during reset.
  assign fifo_req = req_int & rst_n;

  // Counts the RD_LATENCY-1 WAIT cycles; loaded while the rd_en pulse is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_READ_CTRL) begin
      wait_cnt <= WAIT_LOAD_C;
    end else if (state == ST_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // ---- capture / stale filter ----
`ifdef DVS_STALE_DROP_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  logic [TS_W-1:0] age;
  logic            stale;

  // Modular subtraction keeps the age correct across time_us wrap-around.
  assign age   = time_us - fifo_event[TS_W-1:0];
  assign stale = (32'(age) > 32'(STALE_US));
  assign push  = capture && !stale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (capture && stale) begin
      drop_count <= sat_inc16(drop_count);
    end
  end
`else
  logic unused_stale_cfg;

  assign unused_stale_cfg = ^{time_us, (STALE_US > 0)};
  assign push             = capture;
  assign drop_count       = '0;
`endif

  // ---- circular buffer ----
  assign spike_valid = (occupancy != '0);
  assign pop         = spike_valid && spike_ready;
  assign spike_event = spike_valid ? mem[head] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= fifo_event;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
